// File: rtl/sdram_arb_pkg.sv
// Shared types and default frame geometry for the SDRAM frame arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        REQ  = 3'd2,
        XFER = 3'd3,
        UPD  = 3'd4
    } arb_state_e;

    typedef enum logic {
        REQ_WR = 1'b0,
        REQ_RD = 1'b1
    } req_id_e;

    localparam int unsigned DEF_BURST_LEN   = 256;
    localparam int unsigned DEF_FRAME_WORDS = 307200;
    localparam int unsigned DEF_BANK1_BASE  = 524288;

    typedef struct packed {
        arb_state_e state;
        logic       ready_bank;
        logic       frame_ok;
        logic       wr_pend;
        logic       rd_pend;
    } arb_dbg_t;

endpackage

// File: rtl/frame_addr_ctr.sv
// Per-side frame word counter: saturates at or wraps from FRAME_WORDS and
// reports the length of the next burst that still fits inside the frame.
module frame_addr_ctr #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BURST_LEN   = 256,
    parameter bit          WRAP        = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] rem_len_o
);

    localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BURST = ADDR_W'(BURST_LEN);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] left;

    always_comb begin
        sum    = addr_q + len_i;
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (adv_i) begin
            if (sum >= FRAME) addr_d = WRAP ? '0 : FRAME;
            else              addr_d = sum;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) addr_q <= '0;
        else       addr_q <= addr_d;
    end

    assign left      = (addr_q >= FRAME) ? '0 : (FRAME - addr_q);
    assign rem_len_o = (left < BURST) ? left : BURST;
    assign addr_o    = addr_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the SDRAM between camera writes and VGA reads, issuing burst
// commands and ping-ponging two frame banks between the two sides.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned USEDW_W     = 10,
    parameter int unsigned RD_LOW_TH   = 256,
    parameter int unsigned BANK1_BASE  = DEF_BANK1_BASE
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               init_done,
    input  logic [USEDW_W-1:0] wr_usedw,
    input  logic [USEDW_W-1:0] rd_usedw,
    input  logic               wr_frame_start,
    input  logic               rd_frame_start,
    output logic               cmd_req,
    input  logic               cmd_ack,
    output logic               cmd_wr,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic [8:0]         cmd_len,
    input  logic               cmd_done,
    output logic               rd_fifo_clr,
    output logic               wr_bank,
    output logic               rd_bank,
    output logic               busy,
    output arb_dbg_t           dbg
);

    localparam logic [ADDR_W-1:0]  FRAME   = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0]  BANK1   = ADDR_W'(BANK1_BASE);
    localparam logic [USEDW_W-1:0] RD_ROOM = USEDW_W'((1 << USEDW_W) - 1 - BURST_LEN);
    localparam logic [USEDW_W-1:0] RD_LOW  = USEDW_W'(RD_LOW_TH);

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d;
    logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic              ready_bank_q, ready_bank_d, frame_ok_q, frame_ok_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [8:0]        cmd_len_q, cmd_len_d;
    logic              rd_fifo_clr_q, rd_fifo_clr_d;

    logic              wr_clr, wr_adv, rd_clr, rd_adv;
    logic [ADDR_W-1:0] wr_addr, wr_len, rd_addr, rd_len;
    logic              wr_full, rd_ok, rd_urg, wr_ok, grant_valid, grant_wr;
    logic [ADDR_W-1:0] sel_len;

    frame_addr_ctr #(
        .ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .WRAP(1'b0)
    ) u_wr_ctr (
        .clk_i(CLOCK_50), .rst_i(RESET), .clr_i(wr_clr), .adv_i(wr_adv),
        .len_i(ADDR_W'(cmd_len_q)), .addr_o(wr_addr), .rem_len_o(wr_len)
    );

    frame_addr_ctr #(
        .ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN), .WRAP(1'b1)
    ) u_rd_ctr (
        .clk_i(CLOCK_50), .rst_i(RESET), .clr_i(rd_clr), .adv_i(rd_adv),
        .len_i(ADDR_W'(cmd_len_q)), .addr_o(rd_addr), .rem_len_o(rd_len)
    );

    // Urgent reads beat everything; otherwise a write/read tie goes to
    // whichever side did not win the previous grant.
    always_comb begin
        wr_full     = (wr_addr == FRAME);
        rd_ok       = (rd_usedw <= RD_ROOM);
        rd_urg      = rd_ok && (rd_usedw < RD_LOW);
        wr_ok       = !wr_full && (ADDR_W'(wr_usedw) >= wr_len);
        grant_valid = rd_ok || wr_ok;
        if (rd_urg)             grant_wr = 1'b0;
        else if (wr_ok && rd_ok) grant_wr = (last_q == REQ_RD);
        else                    grant_wr = wr_ok;
        sel_len = grant_wr ? wr_len : rd_len;
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        wr_pend_d     = wr_pend_q | wr_frame_start;
        rd_pend_d     = rd_pend_q | rd_frame_start;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        ready_bank_d  = ready_bank_q;
        frame_ok_d    = frame_ok_q;
        cmd_wr_d      = cmd_wr_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        rd_fifo_clr_d = 1'b0;
        wr_clr        = 1'b0;
        wr_adv        = 1'b0;
        rd_clr        = 1'b0;
        rd_adv        = 1'b0;
        case (state_q)
            IDLE: if (init_done) state_d = ARB;
            ARB: begin
                if (wr_pend_q || rd_pend_q) begin
                    // Write event first so a read event sees the new ready bank.
                    if (wr_pend_q) begin
                        wr_pend_d = wr_frame_start;
                        wr_clr    = 1'b1;
                        if (wr_full) begin
                            ready_bank_d = wr_bank_q;
                            wr_bank_d    = ~wr_bank_q;
                            frame_ok_d   = 1'b1;
                        end
                    end
                    if (rd_pend_q) begin
                        rd_pend_d     = rd_frame_start;
                        rd_clr        = 1'b1;
                        rd_fifo_clr_d = 1'b1;
                        rd_bank_d     = ready_bank_d;
                    end
                end else if (grant_valid) begin
                    state_d    = REQ;
                    last_d     = grant_wr ? REQ_WR : REQ_RD;
                    cmd_wr_d   = grant_wr;
                    cmd_len_d  = 9'(sel_len);
                    cmd_addr_d = grant_wr ? ((wr_bank_q ? BANK1 : '0) + wr_addr)
                                          : ((rd_bank_q ? BANK1 : '0) + rd_addr);
                end
            end
            // cmd_req is valid with cmd_wr/addr/len frozen from the first REQ cycle
            // until cmd_ack is sampled high on a rising edge (same-cycle ack allowed).
            REQ:  if (cmd_ack) state_d = XFER;
            XFER: if (cmd_done) state_d = UPD;
            UPD: begin
                wr_adv  = cmd_wr_q;
                rd_adv  = ~cmd_wr_q;
                state_d = ARB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            last_q        <= REQ_RD;
            wr_pend_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            ready_bank_q  <= 1'b1;
            frame_ok_q    <= 1'b0;
            cmd_wr_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            rd_fifo_clr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            wr_pend_q     <= wr_pend_d;
            rd_pend_q     <= rd_pend_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            ready_bank_q  <= ready_bank_d;
            frame_ok_q    <= frame_ok_d;
            cmd_wr_q      <= cmd_wr_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            rd_fifo_clr_q <= rd_fifo_clr_d;
        end
    end

    assign cmd_req     = (state_q == REQ);
    assign cmd_wr      = cmd_wr_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign rd_fifo_clr = rd_fifo_clr_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign busy        = (state_q != IDLE) && (state_q != ARB);

    always_comb begin
        dbg.state      = state_q;
        dbg.ready_bank = ready_bank_q;
        dbg.frame_ok   = frame_ok_q;
        dbg.wr_pend    = wr_pend_q;
        dbg.rd_pend    = rd_pend_q;
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: acts as the SDRAM command controller and
// checks every burst command against a frame-level model of the arbiter.
module tb_sdram_frame_arbiter;
  import sdram_arb_pkg::*;

  localparam int FW = 307200;
  localparam int B1 = 524288;
  localparam int BL = 256;

  // clock / reset
  logic CLOCK_50 = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic init_done = 1'b0;
  logic [9:0] wr_usedw = '0;
  logic [9:0] rd_usedw = '0;
  logic wr_frame_start = 1'b0;
  logic rd_frame_start = 1'b0;
  logic cmd_ack = 1'b0;
  logic cmd_done = 1'b0;
  logic cmd_req, cmd_wr, rd_fifo_clr, wr_bank, rd_bank, busy;
  logic [21:0] cmd_addr;
  logic [8:0] cmd_len;
  arb_dbg_t dbg;

  sdram_frame_arbiter dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .init_done(init_done),
    .wr_usedw(wr_usedw), .rd_usedw(rd_usedw),
    .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
    .rd_fifo_clr(rd_fifo_clr), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .busy(busy), .dbg(dbg)
  );

  int checks = 0;
  int errors = 0;
  int clr_seen = 0;

  always @(negedge CLOCK_50) if (rd_fifo_clr === 1'b1) clr_seen++;

  // frame-level reference model
  int m_wr_addr, m_rd_addr, m_clr;
  bit m_wr_bank, m_rd_bank, m_ready, m_ok, m_last_rd, m_pw, m_pr;
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_wr_addr = 0; m_rd_addr = 0; m_clr = 0;
    m_wr_bank = 0; m_rd_bank = 1; m_ready = 1; m_ok = 0;
    m_last_rd = 1; m_pw = 0; m_pr = 0;
    exp_q.delete();
  endfunction

  function automatic void model_events();
    if (m_pw) begin
      if (m_wr_addr == FW) begin
        m_ready = m_wr_bank;
        m_wr_bank = !m_wr_bank;
        m_ok = 1;
      end
      m_wr_addr = 0;
      m_pw = 0;
    end
    if (m_pr) begin
      m_rd_addr = 0;
      m_rd_bank = m_ready;
      m_clr++;
      m_pr = 0;
    end
  endfunction

  function automatic bit predict(input int wu, input int ru, output logic [31:0] e);
    int wlen, rlen, a;
    bit rok, rurg, wok, gw;
    e = '0;
    rok = (ru <= 1023 - BL);
    rurg = rok && (ru < 256);
    wlen = (FW - m_wr_addr < BL) ? FW - m_wr_addr : BL;
    rlen = (FW - m_rd_addr < BL) ? FW - m_rd_addr : BL;
    wok = (m_wr_addr < FW) && (wu >= wlen);
    if (rurg) gw = 0;
    else if (wok && rok) gw = m_last_rd;
    else if (wok) gw = 1;
    else if (rok) gw = 0;
    else return 0;
    a = gw ? ((m_wr_bank ? B1 : 0) + m_wr_addr) : ((m_rd_bank ? B1 : 0) + m_rd_addr);
    e = {gw, 22'(a), 9'(gw ? wlen : rlen)};
    return 1;
  endfunction

  // driver tasks
  task automatic do_reset();
    RESET = 1'b1; init_done = 1'b0; cmd_ack = 1'b0; cmd_done = 1'b0;
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    clr_seen = 0;
    model_reset();
  endtask

  task automatic expect_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (cmd_req !== 1'b0) begin
        errors++;
        $display("FAIL %s cmd_req got %b exp 0", tag, cmd_req);
      end
    end
  endtask

  task automatic pulse_idle(input bit ev_wr, input bit ev_rd);
    wr_frame_start = ev_wr; rd_frame_start = ev_rd;
    @(negedge CLOCK_50);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    m_pw |= ev_wr; m_pr |= ev_rd;
  endtask

  task automatic run_burst(input int wu, input int ru, input bit ev_wr, input bit ev_rd,
                           output bit got_wr);
    logic [31:0] e, obs;
    int n, c0, d;
    got_wr = 0;
    model_events();
    if (!predict(wu, ru, e)) begin
      ru = 500;
      void'(predict(wu, ru, e));
    end
    wr_usedw = 10'(wu); rd_usedw = 10'(ru);
    exp_q.push_back(e);
    n = 0;
    while (cmd_req !== 1'b1 && n < 30) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (cmd_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout got %b exp 1", cmd_req);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    obs = {cmd_wr, cmd_addr, cmd_len};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL cmd wr/addr/len got %0b/%0d/%0d exp %0b/%0d/%0d",
               obs[31], obs[30:9], obs[8:0], e[31], e[30:9], e[8:0]);
    end
    checks++;
    if ({wr_bank, rd_bank, busy} !== {m_wr_bank, m_rd_bank, 1'b1}) begin
      errors++;
      $display("FAIL banks wr/rd/busy got %b%b%b exp %b%b1", wr_bank, rd_bank, busy, m_wr_bank, m_rd_bank);
    end
    checks++;
    if ({dbg.ready_bank, dbg.frame_ok} !== {m_ready, m_ok} || clr_seen != m_clr) begin
      errors++;
      $display("FAIL frame_state ready/ok/clr got %b/%b/%0d exp %b/%b/%0d",
               dbg.ready_bank, dbg.frame_ok, clr_seen, m_ready, m_ok, m_clr);
    end
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      cmd_done = (i == 0);
      @(negedge CLOCK_50);
      cmd_done = 1'b0;
      checks++;
      if ({cmd_req, cmd_wr, cmd_addr, cmd_len} !== {1'b1, e}) begin
        errors++;
        $display("FAIL req_hold got %b/%h exp 1/%h", cmd_req, {cmd_wr, cmd_addr, cmd_len}, e);
      end
    end
    cmd_ack = 1'b1;
    @(negedge CLOCK_50);
    cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop got %b exp 0", cmd_req);
    end
    c0 = clr_seen;
    wr_frame_start = ev_wr; rd_frame_start = ev_rd;
    @(negedge CLOCK_50);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    if ((ev_wr || ev_rd) && $urandom_range(0, 1) == 1) begin
      wr_frame_start = ev_wr; rd_frame_start = ev_rd;
      @(negedge CLOCK_50);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
    checks++;
    if (clr_seen != c0) begin
      errors++;
      $display("FAIL clr_mid_burst got %0d exp %0d", clr_seen, c0);
    end
    cmd_done = 1'b1;
    @(negedge CLOCK_50);
    cmd_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (cmd_req !== 1'b0) begin
        errors++;
        $display("FAIL done_to_req_gap cycle %0d got %b exp 0", i, cmd_req);
      end
      if (i == 0) @(negedge CLOCK_50);
    end
    got_wr = e[31];
    if (e[31]) m_wr_addr = (m_wr_addr + int'(e[8:0]) > FW) ? FW : m_wr_addr + int'(e[8:0]);
    else m_rd_addr = (m_rd_addr + int'(e[8:0]) >= FW) ? 0 : m_rd_addr + int'(e[8:0]);
    m_last_rd = !e[31];
    m_pw |= ev_wr; m_pr |= ev_rd;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    RESET = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_len, rd_fifo_clr, wr_bank, rd_bank, busy}
        !== {1'b0, 1'b0, 22'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got %b%b_%0d_%0d_%b%b%b%b exp 00_0_0_0010",
               cmd_req, cmd_wr, cmd_addr, cmd_len, rd_fifo_clr, wr_bank, rd_bank, busy);
    end
    checks++;
    if ({dbg.ready_bank, dbg.frame_ok} !== 2'b10) begin
      errors++;
      $display("FAIL reset_frame_state got %b%b exp 10", dbg.ready_bank, dbg.frame_ok);
    end
    RESET = 1'b0;
    wr_usedw = 10'd300; rd_usedw = 10'd900;
    expect_quiet(5, "idle_no_init");
  endtask

  task automatic test_write_first();
    bit g;
    init_done = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if ({cmd_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL arb_cycle req/busy got %b%b exp 00", cmd_req, busy);
    end
    @(negedge CLOCK_50);
    checks++;
    if (cmd_req !== 1'b1) begin
      errors++;
      $display("FAIL arb_latency cmd_req got %b exp 1", cmd_req);
    end
    run_burst(300, 900, 0, 0, g);
    run_burst(300, 900, 0, 0, g);
  endtask

  task automatic test_urgent_read();
    bit g;
    do_reset();
    wr_usedw = 10'd300; rd_usedw = 10'd100; init_done = 1'b1;
    run_burst(300, 100, 0, 0, g);
    checks++;
    if (g !== 1'b0) begin
      errors++;
      $display("FAIL urgent_grant got wr=%b exp wr=0", g);
    end
  endtask

  task automatic test_round_robin();
    bit g;
    logic [3:0] seq;
    do_reset();
    wr_usedw = 10'd600; rd_usedw = 10'd600; init_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_burst(600, 600, 0, 0, g);
      seq[3 - i] = g;
    end
    checks++;
    if (seq !== 4'b1010) begin
      errors++;
      $display("FAIL round_robin got %b exp 1010", seq);
    end
  endtask

  task automatic test_full_frame();
    bit g;
    do_reset();
    wr_usedw = 10'd600; rd_usedw = 10'd900; init_done = 1'b1;
    for (int i = 0; i < FW / BL; i++) run_burst(600, 900, 0, 0, g);
    expect_quiet(10, "wr_saturated");
    pulse_idle(1, 0);
    run_burst(600, 900, 0, 1, g);
    run_burst(0, 600, 0, 0, g);
    checks++;
    if ({rd_bank, wr_bank, clr_seen} !== {1'b0, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL swap rd/wr/clr got %b/%b/%0d exp 0/1/1", rd_bank, wr_bank, clr_seen);
    end
  endtask

  task automatic test_partial_frame();
    bit g;
    do_reset();
    wr_usedw = 10'd600; rd_usedw = 10'd900; init_done = 1'b1;
    for (int i = 0; i < 10; i++) run_burst(600, 900, 0, (i == 9), g);
    for (int i = 0; i < 10; i++) run_burst(600, 900, (i == 9), 0, g);
    run_burst(600, 900, 0, 0, g);
    checks++;
    if ({wr_bank, rd_bank, dbg.frame_ok} !== 3'b010) begin
      errors++;
      $display("FAIL partial wr/rd/ok got %b%b%b exp 010", wr_bank, rd_bank, dbg.frame_ok);
    end
  endtask

  task automatic test_rd_event_mid_burst();
    bit g;
    for (int i = 0; i < 3; i++) run_burst(0, 600, 0, (i == 1), g);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    wr_usedw = 10'd300; rd_usedw = 10'd900; init_done = 1'b1;
    n = 0;
    while (cmd_req !== 1'b1 && n < 30) begin
      @(negedge CLOCK_50);
      n++;
    end
    cmd_ack = 1'b1;
    @(negedge CLOCK_50);
    cmd_ack = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL xfer_busy got %b exp 1", busy);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({cmd_req, wr_bank, rd_bank, busy, cmd_addr, cmd_len} !== {4'b0010, 22'd0, 9'd0}) begin
      errors++;
      $display("FAIL reset_mid_burst req/wr/rd/busy got %b%b%b%b addr %0d len %0d exp 0010 0 0",
               cmd_req, wr_bank, rd_bank, busy, cmd_addr, cmd_len);
    end
  endtask

  task automatic test_random();
    bit g;
    do_reset();
    init_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      run_burst($urandom_range(0, 1023), $urandom_range(0, 1023),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), g);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_first();
    test_urgent_read();
    test_round_robin();
    test_full_frame();
    test_partial_frame();
    test_rd_event_mid_burst();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
